nbit_serial_subtractor: RTL and testbench
=========================================

Name: nbit_serial_subtractor

Overview:
Bit-serial N-bit subtractor that computes diff = a - b - b_in, processing one bit per clock from the LSB up.
- Companion to the parallel ripple adder: it trades area for N cycles of latency.
- Used where a full-width subtract path is not affordable, e.g. iterative compare/divide datapaths.
- Operands are captured on a start handshake. diff, b_out and ovf are published together with a one-cycle done pulse.

Parameters:
n, 8, operand and result width in bits (n >= 2)

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only when idle
a  input  n  minuend; captured on accepted start
b  input  n  subtrahend; captured on accepted start
b_in  input  1  borrow-in; captured on accepted start
busy  output  1  high while a subtraction is in progress
done  output  1  one-cycle pulse: results valid and newly updated
diff  output  n  a - b - b_in, modulo 2^n
b_out  output  1  final borrow: 1 iff unsigned a < b + b_in
ovf  output  1  signed two's-complement overflow of the subtraction

Behaviour:
- States: IDLE, SHIFT, DONE. A bit counter of width clog2(n)+1 counts processed bits.
- Reset: state=IDLE, busy=0, done=0, diff=0, b_out=0, ovf=0, internal registers cleared.
- Reset is synchronous and overrides everything. A reset mid-operation aborts the operation with no done pulse and leaves outputs at their reset values.
- IDLE:
  - If start=1 at edge E0: capture a, b into shift registers, borrow flop <= b_in, count <= 0, state <= SHIFT, busy <= 1.
  - Otherwise hold.
- SHIFT, edges E1..En, one bit per edge, bit i = count:
  - d_i = a_i ^ b_i ^ br
  - br_next = (~a_i & b_i) | (~a_i & br) | (b_i & br)
  - d_i shifts into the internal result register from the MSB side.
  - Operand registers shift right.
  - count increments.
- Completion at edge En, when bit n-1 is processed:
  - diff <= assembled result; b_out <= br_next.
  - ovf <= (a[n-1] != b[n-1]) && (result[n-1] != a[n-1]), using the captured operand MSBs.
  - busy <= 0, done <= 1, state <= DONE.
- DONE: at the next edge, done <= 0 and state <= IDLE.
- start is ignored in SHIFT and in DONE. The earliest back-to-back start is the cycle after done falls, giving a throughput of one result per n+2 cycles.
- Latency: done is high in the cycle following edge En, i.e. n edges after the start edge.
- diff, b_out and ovf change only at the completion edge or on reset. They hold stable through later operations until the next completion.
- Changes to a, b and b_in after the start edge have no effect on the result.
- busy and done are never high together.
- Overflow uses the borrow-in-inclusive result. b_in is not considered in the ovf formula beyond its effect on the result.

Test Plan:
1. n=8, a=100, b=37, b_in=0, pulse start.
   - Required: busy=1 for 8 cycles; done pulses exactly 8 edges after the start edge; diff=63, b_out=0, ovf=0.
2. n=8, a=5, b=10, b_in=0.
   - Required: diff=8'd251, b_out=1, ovf=0.
3. n=8, a=8'h80, b=8'h01.
   - Required: diff=8'h7F, b_out=0, ovf=1.
   - Then a=8'h7F, b=8'hFF. Required: diff=8'h80, b_out=1, ovf=1.
4. n=8, a=0, b=0, b_in=1.
   - Required: diff=8'hFF, b_out=1, ovf=0.
   - Also: change a and b every cycle while busy. Required: result unaffected.
5. Handshake and reset checks.
   - Assert start during SHIFT with different operands: ignored, no second done.
   - Assert rst at cycle 4 of an operation: busy=0, done never pulses, diff=0.
   - A new start after reset completes normally.
6. Parameter override n=4, a=4'h3, b=4'h5, b_in=0.
   - Required: done 4 edges after start; diff=4'hE, b_out=1, ovf=0.
   - Then issue back-to-back ops each started the cycle after done falls. Required: each result is correct.

Source files
------------

// File: rtl/nbit_serial_subtractor_if.sv
`default_nettype none
// ============================================================================
//  Module      : nbit_serial_subtractor_if
//  Description : Start/result bundle between a requester and the bit-serial
//                subtractor.
//  Revision    : 1.0 - initial release
// ============================================================================
interface nbit_serial_subtractor_if #(
  parameter int n = 8
);
  logic         start;
  logic [n-1:0] a;
  logic [n-1:0] b;
  logic         b_in;
  logic         busy;
  logic         done;
  logic [n-1:0] diff;
  logic         b_out;
  logic         ovf;

  modport master (
    output start, a, b, b_in,
    input  busy, done, diff, b_out, ovf
  );

  modport slave (
    input  start, a, b, b_in,
    output busy, done, diff, b_out, ovf
  );
endinterface
`default_nettype wire

// File: rtl/nbit_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : nbit_serial_subtractor
//  Description : Bit-serial a - b - b_in, one bit per clock from the LSB.
//  Revision    : 1.0 - initial release
// ============================================================================
module nbit_serial_subtractor #(
  parameter int n = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  nbit_serial_subtractor_if.slave  s
);

  localparam int CW = $clog2(n) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next_state;

  logic [n-1:0]    r_a;
  logic [n-1:0]    r_b;
  logic            r_br;
  logic [CW-1:0]   r_cnt;
  logic [n-1:0]    r_res;
  logic [n-1:0]    r_diff;
  logic            r_bout;
  logic            r_ovf;

  logic            w_d;
  logic            w_br_next;
  logic            w_last;
  logic [n-1:0]    w_res_next;

  // Full-subtractor cell on the current LSB of the operand shift registers.
  assign w_d        = r_a[0] ^ r_b[0] ^ r_br;
  assign w_br_next  = (~r_a[0] & r_b[0]) | (~r_a[0] & r_br) | (r_b[0] & r_br);
  assign w_res_next = {w_d, r_res[n-1:1]};
  assign w_last     = (r_cnt == CW'(n - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    s.busy       = 1'b0;
    s.done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (s.start) begin
          w_next_state = S_SHIFT;
        end
      end
      S_SHIFT: begin
        s.busy = 1'b1;
        if (w_last) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        s.done       = 1'b1;
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_br   <= 1'b0;
      r_cnt  <= '0;
      r_res  <= '0;
      r_diff <= '0;
      r_bout <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (s.start) begin
            r_a   <= s.a;
            r_b   <= s.b;
            r_br  <= s.b_in;
            r_cnt <= '0;
            r_res <= '0;
          end
        end
        S_SHIFT: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_br  <= w_br_next;
          r_res <= w_res_next;
          r_cnt <= r_cnt + CW'(1);
          // On the last bit the operand LSBs are the original sign bits.
          if (w_last) begin
            r_diff <= w_res_next;
            r_bout <= w_br_next;
            r_ovf  <= (r_a[0] ^ r_b[0]) & (w_d ^ r_a[0]);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign s.diff  = r_diff;
  assign s.b_out = r_bout;
  assign s.ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_nbit_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nbit_serial_subtractor
//  Description : Directed bench for the bit-serial subtractor, n=8 and n=4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nbit_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       sel;
  logic       r_start;
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic       r_bin;
  logic       chk_en;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  nbit_serial_subtractor_if #(.n(8)) if8 ();
  nbit_serial_subtractor_if #(.n(4)) if4 ();

  assign if8.start = r_start & ~sel;
  assign if8.a     = r_a;
  assign if8.b     = r_b;
  assign if8.b_in  = r_bin;
  assign if4.start = r_start & sel;
  assign if4.a     = r_a[3:0];
  assign if4.b     = r_b[3:0];
  assign if4.b_in  = r_bin;

  nbit_serial_subtractor #(.n(8)) u_dut8 (.clk(clk), .rst(rst), .s(if8));
  nbit_serial_subtractor #(.n(4)) u_dut4 (.clk(clk), .rst(rst), .s(if4));

  // Selected-instance view used by the directed checks.
  logic       t_busy, t_done, t_bout, t_ovf;
  logic [7:0] t_diff;
  always_comb begin
    t_busy = sel ? if4.busy  : if8.busy;
    t_done = sel ? if4.done  : if8.done;
    t_bout = sel ? if4.b_out : if8.b_out;
    t_ovf  = sel ? if4.ovf   : if8.ovf;
    t_diff = sel ? {4'b0, if4.diff} : if8.diff;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Result from plain arithmetic: {b_out, ovf, diff[7:0]}.
  function automatic logic [9:0] model_sub(input int w, input int a, input int b, input int bi);
    int m  = 1 << w;
    int h  = m / 2;
    int d  = a - b - bi;
    int sa = (a >= h) ? a - m : a;
    int sb = (b >= h) ? b - m : b;
    int sd = sa - sb - bi;
    logic [7:0] dv = 8'((d + m) % m);
    return {d < 0, (sd < -h) || (sd > h - 1), dv};
  endfunction

  // Model inputs per instance: index 0 = n8, index 1 = n4.
  logic ms_start [2];
  int   ms_a     [2];
  int   ms_b     [2];
  int   ms_bi    [2];
  int   mw       [2];
  always_comb begin
    ms_start[0] = if8.start;  ms_start[1] = if4.start;
    ms_a[0]     = int'(if8.a); ms_a[1]    = int'(if4.a);
    ms_b[0]     = int'(if8.b); ms_b[1]    = int'(if4.b);
    ms_bi[0]    = int'(if8.b_in); ms_bi[1] = int'(if4.b_in);
    mw[0]       = 8;          mw[1]       = 4;
  end

  logic       m_busy [2];
  logic       m_done [2];
  int         m_cnt  [2];
  logic [9:0] m_pend [2];
  logic [9:0] m_out  [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_busy[k] <= 1'b0;
        m_done[k] <= 1'b0;
        m_cnt[k]  <= 0;
        m_out[k]  <= '0;
      end else if (m_done[k]) begin
        m_done[k] <= 1'b0;
      end else if (m_busy[k]) begin
        m_cnt[k] <= m_cnt[k] - 1;
        if (m_cnt[k] == 1) begin
          m_busy[k] <= 1'b0;
          m_done[k] <= 1'b1;
          m_out[k]  <= m_pend[k];
        end
      end else if (ms_start[k]) begin
        m_busy[k] <= 1'b1;
        m_cnt[k]  <= mw[k];
        m_pend[k] <= model_sub(mw[k], ms_a[k], ms_b[k], ms_bi[k]);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m8.busy", if8.busy, m_busy[0]);
      chk("m8.done", if8.done, m_done[0]);
      chk("m8.diff", if8.diff, m_out[0][7:0]);
      chk("m8.bout", if8.b_out, m_out[0][9]);
      chk("m8.ovf",  if8.ovf,   m_out[0][8]);
      chk("m4.busy", if4.busy, m_busy[1]);
      chk("m4.done", if4.done, m_done[1]);
      chk("m4.diff", if4.diff, m_out[1][3:0]);
      chk("m4.bout", if4.b_out, m_out[1][9]);
      chk("m4.ovf",  if4.ovf,   m_out[1][8]);
    end
  end

  // One operation with hand-computed expectations; scramble changes operands
  // while busy, noise raises start with other operands during SHIFT/DONE.
  task automatic run(input logic s, input logic [7:0] a, input logic [7:0] b, input logic bi,
                     input int ed, input int eb, input int eo,
                     input logic scramble, input logic noise, input string nm);
    int lat   = 0;
    int nbusy = 0;
    int ndone = 0;
    int elat  = s ? 4 : 8;
    @(negedge clk);
    sel = s; r_a = a; r_b = b; r_bin = bi; r_start = 1'b1;
    @(negedge clk);
    r_start = 1'b0;
    while (!t_done && lat < 50) begin
      if (t_busy) nbusy++;
      if (scramble || noise) begin
        r_a = 8'($urandom); r_b = 8'($urandom); r_bin = 1'($urandom);
      end
      if (noise && lat == 2) r_start = 1'b1;
      @(negedge clk);
      lat++;
    end
    chk({nm, ".latency"}, lat, elat);
    chk({nm, ".busycyc"}, nbusy, elat);
    chk({nm, ".diff"}, t_diff, ed);
    chk({nm, ".bout"}, t_bout, eb);
    chk({nm, ".ovf"},  t_ovf,  eo);
    if (noise) begin
      @(negedge clk);
      r_start = 1'b0;
      for (int i = 0; i < 12; i++) begin
        if (t_done || t_busy) ndone++;
        @(negedge clk);
      end
      chk({nm, ".no_second_op"}, ndone, 0);
    end
    r_start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd;
    rst = 1'b1; sel = 1'b0; r_start = 1'b0; r_a = '0; r_b = '0; r_bin = 1'b0; chk_en = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("reset.busy8", if8.busy, 0);
    chk("reset.done8", if8.done, 0);
    chk("reset.diff8", if8.diff, 0);
    chk("reset.bout8", if8.b_out, 0);
    chk("reset.ovf8",  if8.ovf, 0);
    chk("reset.diff4", if4.diff, 0);
    rst = 1'b0;

    run(1'b0, 8'd100, 8'd37, 1'b0, 63, 0, 0, 1'b0, 1'b0, "t1");
    run(1'b0, 8'd5,   8'd10, 1'b0, 251, 1, 0, 1'b0, 1'b0, "t2");
    run(1'b0, 8'h80,  8'h01, 1'b0, 8'h7F, 0, 1, 1'b0, 1'b0, "t3a");
    run(1'b0, 8'h7F,  8'hFF, 1'b0, 8'h80, 1, 1, 1'b0, 1'b0, "t3b");
    run(1'b0, 8'h00,  8'h00, 1'b1, 8'hFF, 1, 0, 1'b1, 1'b0, "t4");
    run(1'b0, 8'h55,  8'h2A, 1'b1, 8'h2A, 0, 0, 1'b0, 1'b1, "t5_noise");

    // Reset in the fourth cycle of an operation aborts it.
    @(negedge clk);
    sel = 1'b0; r_a = 8'hC8; r_b = 8'h03; r_bin = 1'b0; r_start = 1'b1;
    @(negedge clk);
    r_start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_rst.busy", if8.busy, 0);
    chk("t5_rst.diff", if8.diff, 0);
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      if (if8.done) nd++;
      @(negedge clk);
    end
    chk("t5_rst.no_done", nd, 0);
    chk("t5_rst.diff_held", if8.diff, 0);
    run(1'b0, 8'hC8, 8'h03, 1'b0, 8'hC5, 0, 0, 1'b0, 1'b0, "t5_after");

    run(1'b1, 8'h03, 8'h05, 1'b0, 4'hE, 1, 0, 1'b0, 1'b0, "t6");
    run(1'b1, 8'h08, 8'h01, 1'b0, 4'h7, 0, 1, 1'b0, 1'b0, "t6_b2b1");
    run(1'b1, 8'h07, 8'h0F, 1'b1, 4'h7, 1, 0, 1'b0, 1'b0, "t6_b2b2");
    run(1'b1, 8'h0A, 8'h03, 1'b1, 4'h6, 0, 1, 1'b0, 1'b0, "t6_b2b3");
    run(1'b1, 8'h00, 8'h00, 1'b0, 4'h0, 0, 0, 1'b0, 1'b0, "t6_b2b4");

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
